// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display block.
// Scan states, blank encodings and the leading-zero test used during digit select.
package hex_disp_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned DATA_W     = MAX_DIGITS * NIB_W;
  localparam int unsigned SEG_W      = 7;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = 8'hFF;

  // True when every nibble from idx up to the top scanned digit is zero.
  function automatic logic lead_zero(input logic [DATA_W-1:0] val,
                                     input logic [2:0]        idx,
                                     input int unsigned       digits);
    logic z;
    z = 1'b1;
    for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
      if ((k >= 32'(idx)) && (k < digits) && (val[NIB_W*k +: NIB_W] != 4'h0)) begin
        z = 1'b0;
      end
    end
    return z;
  endfunction

endpackage

// File: rtl/hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern (gfedcba).
module hex_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    case (hex)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Scan controller and write arbiter for an 8-digit multiplexed seven-segment display.
// Pending value is latched into the shown value only when a frame begins.
module hex_scan_ctrl
  import hex_disp_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [31:0] cpu_data,
  input  logic        dbg_we,
  input  logic [31:0] dbg_data,
  input  logic        dbg_hold,
  input  logic        lzb_en,
  output logic        cpu_ack,
  output logic        dbg_ack,
  output logic [6:0]  to_hex,
  output logic [7:0]  to_hex_ans
);

  localparam int unsigned CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = 3;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]      pending_q, pending_d;
  logic [DATA_W-1:0]      shown_q, shown_d;
  logic [SEG_W-1:0]       to_hex_q, to_hex_d;
  logic [MAX_DIGITS-1:0]  to_hex_ans_q, to_hex_ans_d;
  logic                   cpu_ack_q, cpu_ack_d;
  logic                   dbg_ack_q, dbg_ack_d;

  logic [NIB_W-1:0]       nibble_c;
  logic [SEG_W-1:0]       seg_c;
  logic                   blank_digit_c;

  assign nibble_c      = shown_q[{idx_q, 2'b00} +: NIB_W];
  assign blank_digit_c = lzb_en && (idx_q != '0) && lead_zero(shown_q, idx_q, DIGITS);

  hex_decoder u_hex_decoder (
    .hex   (nibble_c),
    .seg_c (seg_c)
  );

  // Write arbitration: debug has priority, CPU is gated by dbg_hold.
  always_comb begin
    pending_d = pending_q;
    cpu_ack_d = 1'b0;
    dbg_ack_d = 1'b0;
    if (dbg_we) begin
      pending_d = dbg_data;
      dbg_ack_d = 1'b1;
    end else if (cpu_we && !dbg_hold) begin
      pending_d = cpu_data;
      cpu_ack_d = 1'b1;
    end
  end

  // Scan sequencer; segment and anode registers change only on state transitions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    shown_d      = shown_q;
    to_hex_d     = to_hex_q;
    to_hex_ans_d = to_hex_ans_q;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          if (blank_digit_c) begin
            to_hex_d     = SEG_BLANK;
            to_hex_ans_d = ANODE_OFF;
          end else begin
            to_hex_d     = seg_c;
            to_hex_ans_d = ~(MAX_DIGITS'(1) << idx_q);
          end
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d      = BLANK;
          cnt_d        = '0;
          idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          to_hex_d     = SEG_BLANK;
          to_hex_ans_d = ANODE_OFF;
          // Frame snapshot: a write landing this same cycle waits for the next frame.
          if (idx_d == '0) begin
            shown_d = pending_q;
          end
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      shown_q      <= '0;
      to_hex_q     <= SEG_BLANK;
      to_hex_ans_q <= ANODE_OFF;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      shown_q      <= shown_d;
      to_hex_q     <= to_hex_d;
      to_hex_ans_q <= to_hex_ans_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
    end
  end

  assign to_hex     = to_hex_q;
  assign to_hex_ans = to_hex_ans_q;
  assign cpu_ack    = cpu_ack_q;
  assign dbg_ack    = dbg_ack_q;

endmodule
